// File: rtl/async_dual_ram.sv
// Simple dual-port register-file RAM: one write port, one registered read port, one clock.
// Optional ASYN_DUAL_RAM_BYPASS_EN forwards write data to the read port on a same-address collision.
module async_dual_ram #(
  parameter int RAM_WIDTH = 16,
  parameter int RAM_DEPTH = 8,
  parameter int ADDR_SIZE = 3
) (
  input  logic                 clk,
  input  logic                 clr_n,
  input  logic                 wr_en,
  input  logic                 rd_en,
  input  logic [ADDR_SIZE-1:0] wr_ad,
  input  logic [ADDR_SIZE-1:0] rd_ad,
  input  logic [RAM_WIDTH-1:0] data_in,
  output logic [RAM_WIDTH-1:0] data_out
);

  localparam logic [ADDR_SIZE:0] DEPTH_L = (ADDR_SIZE+1)'(RAM_DEPTH);

  logic [RAM_WIDTH-1:0] mem [RAM_DEPTH];
  logic                 wr_ok;
  logic                 rd_ok;
  logic                 collide;

  // Addresses beyond the populated depth are treated as holes: writes drop, reads return zero.
  assign wr_ok   = ({1'b0, wr_ad} < DEPTH_L);
  assign rd_ok   = ({1'b0, rd_ad} < DEPTH_L);
  assign collide = wr_en && (wr_ad == rd_ad);

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      for (int i = 0; i < RAM_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en && wr_ok) begin
      mem[wr_ad] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      data_out <= '0;
    end else if (rd_en) begin
      if (!rd_ok) begin
        data_out <= '0;
`ifdef ASYN_DUAL_RAM_BYPASS_EN
      end else if (collide) begin
        data_out <= data_in;
`endif
      end else begin
        // Without bypass, a colliding read sees the pre-write word.
        data_out <= mem[rd_ad];
      end
    end
  end

`ifndef ASYN_DUAL_RAM_BYPASS_EN
  logic unused_collide;
  assign unused_collide = collide;
`endif

endmodule

// File: tb/tb_async_dual_ram.sv
// Self-checking bench for async_dual_ram: a depth-8 and a depth-6 instance share stimulus
// and are compared against an array-based reference model.
module tb_async_dual_ram;

`ifdef ASYN_DUAL_RAM_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        clr_n;
  logic        wr_en;
  logic        rd_en;
  logic [2:0]  wr_ad;
  logic [2:0]  rd_ad;
  logic [15:0] data_in;
  logic [15:0] data_out;
  logic [15:0] data_out6;

  int errors = 0;
  int checks = 0;

  logic [15:0] m8 [8];
  logic [15:0] m6 [8];
  logic [15:0] exp8;
  logic [15:0] exp6;
  logic [15:0] exp_q [$];
  logic [15:0] e;

  async_dual_ram #(.RAM_WIDTH(16), .RAM_DEPTH(8), .ADDR_SIZE(3)) dut (
    .clk(clk), .clr_n(clr_n), .wr_en(wr_en), .rd_en(rd_en),
    .wr_ad(wr_ad), .rd_ad(rd_ad), .data_in(data_in), .data_out(data_out)
  );

  async_dual_ram #(.RAM_WIDTH(16), .RAM_DEPTH(6), .ADDR_SIZE(3)) dut6 (
    .clk(clk), .clr_n(clr_n), .wr_en(wr_en), .rd_en(rd_en),
    .wr_ad(wr_ad), .rd_ad(rd_ad), .data_in(data_in), .data_out(data_out6)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic model_clear();
    for (int i = 0; i < 8; i++) begin
      m8[i] = '0;
      m6[i] = '0;
    end
    exp8 = '0;
    exp6 = '0;
  endtask

  // Driver: one clock cycle of stimulus, reference model updated at the edge.
  task automatic cycle(input logic we, input logic re, input logic [2:0] wa,
                       input logic [2:0] ra, input logic [15:0] din);
    wr_en   = we;
    rd_en   = re;
    wr_ad   = wa;
    rd_ad   = ra;
    data_in = din;
    @(posedge clk);
    if (re) begin
      exp8 = (BYP && we && wa == ra) ? din : m8[ra];
      if (ra >= 3'd6) exp6 = '0;
      else exp6 = (BYP && we && wa == ra) ? din : m6[ra];
    end
    if (we) begin
      m8[wa] = din;
      if (wa < 3'd6) m6[wa] = din;
    end
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  // Asynchronous clear pulse placed between clock edges.
  task automatic pulse_clear();
    #2 clr_n = 1'b0;
    #1 model_clear();
    #2 clr_n = 1'b1;
  endtask

  task automatic test_reset();
    clr_n = 1'b0;
    wr_en = 1'b0; rd_en = 1'b0; wr_ad = '0; rd_ad = '0; data_in = '0;
    model_clear();
    #3;
    checks++;
    if (data_out !== 16'h0) begin
      errors++; $display("FAIL reset_out: got %h expected 0000", data_out);
    end
    @(posedge clk); #1;
    cycle(1'b1, 1'b0, 3'd0, 3'd0, 16'hFFFF);
    checks++;
    if (data_out !== 16'h0) begin
      errors++; $display("FAIL reset_ignore_en: got %h expected 0000", data_out);
    end
    #2 clr_n = 1'b1;
    #2;
    model_clear();
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 1'b1, 3'd0, 3'(i), 16'h0);
      checks++;
      if (data_out !== 16'h0) begin
        errors++; $display("FAIL reset_mem[%0d]: got %h expected 0000", i, data_out);
      end
    end
  endtask

  task automatic test_write_read();
    pulse_clear();
    cycle(1'b1, 1'b0, 3'd0, 3'd0, 16'd9);
    cycle(1'b1, 1'b0, 3'd1, 3'd0, 16'd19);
    cycle(1'b1, 1'b0, 3'd4, 3'd0, 16'd14);
    cycle(1'b1, 1'b0, 3'd6, 3'd0, 16'd25);
    exp_q.push_back(16'd9);
    exp_q.push_back(16'd19);
    exp_q.push_back(16'd14);
    exp_q.push_back(16'd25);
    cycle(1'b0, 1'b1, 3'd0, 3'd0, 16'h0);
    e = exp_q.pop_front();
    checks++;
    if (data_out !== e) begin errors++; $display("FAIL read0: got %0d expected %0d", data_out, e); end
    cycle(1'b0, 1'b1, 3'd0, 3'd1, 16'h0);
    e = exp_q.pop_front();
    checks++;
    if (data_out !== e) begin errors++; $display("FAIL read1: got %0d expected %0d", data_out, e); end
    cycle(1'b0, 1'b1, 3'd0, 3'd4, 16'h0);
    e = exp_q.pop_front();
    checks++;
    if (data_out !== e) begin errors++; $display("FAIL read4: got %0d expected %0d", data_out, e); end
    cycle(1'b0, 1'b1, 3'd0, 3'd6, 16'h0);
    e = exp_q.pop_front();
    checks++;
    if (data_out !== e) begin errors++; $display("FAIL read6: got %0d expected %0d", data_out, e); end
  endtask

  task automatic test_clear_mid_read();
    cycle(1'b0, 1'b1, 3'd0, 3'd4, 16'h0);
    checks++;
    if (data_out !== 16'd14) begin errors++; $display("FAIL clr_pre: got %0d expected 14", data_out); end
    #2 clr_n = 1'b0;
    #1;
    model_clear();
    checks++;
    if (data_out !== 16'd0) begin errors++; $display("FAIL clr_immediate: got %0d expected 0", data_out); end
    #2 clr_n = 1'b1;
    cycle(1'b0, 1'b1, 3'd0, 3'd6, 16'h0);
    checks++;
    if (data_out !== 16'd0) begin errors++; $display("FAIL clr_read6: got %0d expected 0", data_out); end
  endtask

  task automatic test_hold();
    cycle(1'b1, 1'b0, 3'd1, 3'd0, 16'd19);
    cycle(1'b0, 1'b1, 3'd0, 3'd1, 16'h0);
    checks++;
    if (data_out !== 16'd19) begin errors++; $display("FAIL hold_read: got %0d expected 19", data_out); end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 3'd0, 3'(i + 2), 16'h0);
      checks++;
      if (data_out !== 16'd19) begin errors++; $display("FAIL hold_cycle%0d: got %0d expected 19", i, data_out); end
    end
  endtask

  task automatic test_collision();
    cycle(1'b1, 1'b0, 3'd3, 3'd0, 16'h00AA);
    cycle(1'b1, 1'b1, 3'd3, 3'd3, 16'h1234);
    e = BYP ? 16'h1234 : 16'h00AA;
    checks++;
    if (data_out !== e) begin errors++; $display("FAIL collision: got %h expected %h", data_out, e); end
    cycle(1'b0, 1'b1, 3'd0, 3'd3, 16'h0);
    checks++;
    if (data_out !== 16'h1234) begin errors++; $display("FAIL collision_after: got %h expected 1234", data_out); end
  endtask

  task automatic test_concurrent();
    cycle(1'b1, 1'b0, 3'd6, 3'd0, 16'd25);
    cycle(1'b1, 1'b1, 3'd2, 3'd6, 16'h5555);
    checks++;
    if (data_out !== 16'd25) begin errors++; $display("FAIL concurrent_rd: got %0d expected 25", data_out); end
    cycle(1'b0, 1'b1, 3'd0, 3'd2, 16'h0);
    checks++;
    if (data_out !== 16'h5555) begin errors++; $display("FAIL concurrent_wr: got %h expected 5555", data_out); end
  endtask

  task automatic test_out_of_range();
    pulse_clear();
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 3'(i), 3'd0, 16'h0100 + 16'(i));
    cycle(1'b1, 1'b0, 3'd7, 3'd0, 16'd7);
    cycle(1'b1, 1'b0, 3'd6, 3'd0, 16'hBEEF);
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, 1'b1, 3'd0, 3'(i), 16'h0);
      checks++;
      if (data_out6 !== 16'h0100 + 16'(i)) begin
        errors++; $display("FAIL oor_word%0d: got %h expected %h", i, data_out6, 16'h0100 + 16'(i));
      end
    end
    cycle(1'b0, 1'b1, 3'd0, 3'd7, 16'h0);
    checks++;
    if (data_out6 !== 16'h0) begin errors++; $display("FAIL oor_read7: got %h expected 0000", data_out6); end
    cycle(1'b0, 1'b1, 3'd7, 3'd6, 16'h1111);
    checks++;
    if (data_out6 !== 16'h0) begin errors++; $display("FAIL oor_read6: got %h expected 0000", data_out6); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 49) == 0) pulse_clear();
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
            3'($urandom_range(0, 7)), 16'($urandom));
      checks++;
      if (data_out !== exp8) begin errors++; $display("FAIL rand8[%0d]: got %h expected %h", n, data_out, exp8); end
      checks++;
      if (data_out6 !== exp6) begin errors++; $display("FAIL rand6[%0d]: got %h expected %h", n, data_out6, exp6); end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_clear_mid_read();
    test_hold();
    test_collision();
    test_concurrent();
    test_out_of_range();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end

endmodule
